// File: rtl/bcd_to_binary.sv
// ---------------------------------------------------------------------------
// bcd_to_binary
//
// Sequential packed-BCD to binary converter using the reverse double-dabble
// algorithm: one shift/adjust step per clock, OUTPUT_WIDTH steps per result.
//
// Parameters
//   DECIMAL_DIGITS : number of packed BCD digits on i_bcd
//   OUTPUT_WIDTH   : binary result width (10**DECIMAL_DIGITS <= 2**OUTPUT_WIDTH)
//
// Ports
//   clk      : rising-edge clock
//   reset    : synchronous, active-high reset
//   i_start  : conversion request, only looked at while idle
//   i_bcd    : packed BCD operand, most significant digit in the top nibble
//   o_binary : registered result, held until the next result or reset
//   o_dv     : one-cycle result-valid strobe
//   o_busy   : high whenever the converter is not idle
//   o_err    : invalid-digit flag, valid alongside o_dv
// ---------------------------------------------------------------------------
module bcd_to_binary #(
    parameter int DECIMAL_DIGITS = 6,
    parameter int OUTPUT_WIDTH   = 24
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_start,
    input  logic [4*DECIMAL_DIGITS-1:0] i_bcd,
    output logic [OUTPUT_WIDTH-1:0]     o_binary,
    output logic                        o_dv,
    output logic                        o_busy,
    output logic                        o_err
);

    localparam int BCD_W = 4 * DECIMAL_DIGITS;
    localparam int CNT_W = $clog2(OUTPUT_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_t;

    state_t                  state_reg,  state_next;
    logic [BCD_W-1:0]        bcd_reg,    bcd_next;
    logic [OUTPUT_WIDTH-1:0] acc_reg,    acc_next;
    logic [CNT_W-1:0]        cnt_reg,    cnt_next;
    logic [OUTPUT_WIDTH-1:0] binary_reg, binary_next;
    logic                    err_reg,    err_next;

    // Per-digit helpers
    logic [DECIMAL_DIGITS-1:0] digit_bad;
    logic [BCD_W-1:0]          shifted_bcd;
    logic [BCD_W-1:0]          adjusted_bcd;
    logic [OUTPUT_WIDTH-1:0]   shifted_acc;
    logic                      any_bad;
    logic                      last_step;

    // {bcd, acc} >> 1: the BCD LSB drops into the accumulator MSB.
    assign shifted_bcd = {1'b0, bcd_reg[BCD_W-1:1]};
    assign shifted_acc = {bcd_reg[0], acc_reg[OUTPUT_WIDTH-1:1]};

    generate
        for (genvar gi = 0; gi < DECIMAL_DIGITS; gi++) begin : g_digit
            logic [3:0] nibble;

            assign digit_bad[gi] = (i_bcd[4*gi +: 4] > 4'd9);

            // Halving a digit whose upper neighbour shifted a one into it
            // leaves 8 + n/2; subtracting 3 restores the decimal weight
            // (10/2 = 5 instead of 8). Strictly nibble-local, no carries.
            assign nibble = shifted_bcd[4*gi +: 4];
            assign adjusted_bcd[4*gi +: 4] = (nibble >= 4'd8) ? (nibble - 4'd3) : nibble;
        end
    endgenerate

    assign any_bad   = |digit_bad;
    assign last_step = (cnt_reg == CNT_W'(OUTPUT_WIDTH - 1));

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            bcd_reg    <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            binary_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            bcd_reg    <= bcd_next;
            acc_reg    <= acc_next;
            cnt_reg    <= cnt_next;
            binary_reg <= binary_next;
            err_reg    <= err_next;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_next  = state_reg;
        bcd_next    = bcd_reg;
        acc_next    = acc_reg;
        cnt_next    = cnt_reg;
        binary_next = binary_reg;
        err_next    = err_reg;

        case (state_reg)
            IDLE: begin
                if (i_start) begin
                    bcd_next = i_bcd;
                    acc_next = '0;
                    cnt_next = '0;
                    if (any_bad) begin
                        // Invalid operand: report immediately, no conversion.
                        binary_next = '0;
                        err_next    = 1'b1;
                        state_next  = DONE;
                    end else begin
                        state_next  = CONVERT;
                    end
                end
            end

            CONVERT: begin
                bcd_next = adjusted_bcd;
                acc_next = shifted_acc;
                cnt_next = cnt_reg + CNT_W'(1);
                if (last_step) begin
                    binary_next = shifted_acc;
                    err_next    = 1'b0;
                    state_next  = DONE;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are decoded straight from registers only.
    assign o_binary = binary_reg;
    assign o_err    = err_reg;
    assign o_dv     = (state_reg == DONE);
    assign o_busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_bcd_to_binary.sv
// ---------------------------------------------------------------------------
// tb_bcd_to_binary
//
// Directed and swept checks of bcd_to_binary with its default parameters.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_bcd_to_binary;

    logic        clk;
    logic        reset;
    logic        i_start;
    logic [23:0] i_bcd;
    logic [23:0] o_binary;
    logic        o_dv;
    logic        o_busy;
    logic        o_err;

    int checks = 0;
    int passed = 0;

    bcd_to_binary #(
        .DECIMAL_DIGITS(6),
        .OUTPUT_WIDTH  (24)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .i_start (i_start),
        .i_bcd   (i_bcd),
        .o_binary(o_binary),
        .o_dv    (o_dv),
        .o_busy  (o_busy),
        .o_err   (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs a decimal number 0..999999 into six BCD digits.
    function automatic logic [23:0] to_bcd(input int value);
        logic [23:0] r;
        int v;
        r = '0;
        v = value;
        for (int d = 0; d < 6; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Pulses i_start for one capture edge, scrambles i_bcd afterwards, then
    // waits (bounded) for o_dv. lat = edges after capture until o_dv is seen
    // (-1 on timeout); busy_n = cycles with o_busy high up to and including o_dv.
    task automatic run_conv(input logic [23:0] bcd, output int lat, output int busy_n,
                            output logic [23:0] bin, output logic err);
        @(negedge clk);
        i_bcd   = bcd;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_bcd   = 24'h5A5A5A;
        lat     = -1;
        busy_n  = 0;
        bin     = 'x;
        err     = 1'bx;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            if (o_busy) busy_n++;
            if (o_dv) begin
                lat = i;
                bin = o_binary;
                err = o_err;
                break;
            end
        end
        $display("conv bcd=%06h lat=%0d bin=%06h err=%0b", bcd, lat, bin, err);
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        i_start = 1'b0;
        i_bcd   = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({o_binary, o_dv, o_busy, o_err} !== 27'd0)
            $display("FAIL reset_state got bin=%06h dv=%b busy=%b err=%b want all 0",
                     o_binary, o_dv, o_busy, o_err);
        else passed++;
        reset = 1'b0;
        $display("reset released");
    endtask

    task automatic test_max();
        int lat, busy_n;
        logic [23:0] bin;
        logic err;
        run_conv(24'h999999, lat, busy_n, bin, err);
        checks++;
        if (lat !== 24) $display("FAIL max_latency got %0d want 24", lat);
        else passed++;
        checks++;
        if (bin !== 24'h0F423F || err !== 1'b0)
            $display("FAIL max_value got %06h err=%b want 0f423f err=0", bin, err);
        else passed++;
        @(negedge clk);
        checks++;
        if (o_dv !== 1'b0 || o_busy !== 1'b0)
            $display("FAIL max_single_pulse got dv=%b busy=%b want dv=0 busy=0", o_dv, o_busy);
        else passed++;
        checks++;
        if (busy_n !== 25) $display("FAIL max_busy_cycles got %0d want 25", busy_n);
        else passed++;
        checks++;
        if (o_binary !== 24'h0F423F) $display("FAIL max_hold got %06h want 0f423f", o_binary);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int lat, busy_n;
        logic [23:0] bin;
        logic err;
        run_conv(24'h123456, lat, busy_n, bin, err);
        checks++;
        if (lat !== 24 || bin !== 24'h01E240 || err !== 1'b0)
            $display("FAIL b2b_first got lat=%0d bin=%06h err=%b want 24 01e240 0", lat, bin, err);
        else passed++;
        // Next start is presented in the first idle cycle after DONE.
        run_conv(24'h000000, lat, busy_n, bin, err);
        checks++;
        if (lat !== 24 || bin !== 24'h000000 || err !== 1'b0)
            $display("FAIL b2b_zero got lat=%0d bin=%06h err=%b want 24 000000 0", lat, bin, err);
        else passed++;
        @(negedge clk);
        checks++;
        if (o_dv !== 1'b0) $display("FAIL b2b_single_pulse got dv=%b want 0", o_dv);
        else passed++;
    endtask

    task automatic test_error();
        int lat, busy_n;
        logic [23:0] bin;
        logic err;
        // Leave a nonzero result behind so the forced zero is observable.
        run_conv(24'h000077, lat, busy_n, bin, err);
        checks++;
        if (bin !== 24'h00004D) $display("FAIL err_setup got %06h want 00004d", bin);
        else passed++;
        run_conv(24'h12A456, lat, busy_n, bin, err);
        checks++;
        if (lat !== 0 || bin !== 24'h000000 || err !== 1'b1)
            $display("FAIL err_digit got lat=%0d bin=%06h err=%b want 0 000000 1", lat, bin, err);
        else passed++;
        run_conv(24'h000010, lat, busy_n, bin, err);
        checks++;
        if (lat !== 24 || bin !== 24'h00000A || err !== 1'b0)
            $display("FAIL err_recover got lat=%0d bin=%06h err=%b want 24 00000a 0", lat, bin, err);
        else passed++;
    endtask

    task automatic test_start_held();
        int dv_n, dv_at;
        logic [23:0] dv_bin;
        logic busy25, busy26;
        dv_n   = 0;
        dv_at  = -1;
        dv_bin = 'x;
        busy25 = 1'bx;
        busy26 = 1'bx;
        @(negedge clk);
        i_bcd   = 24'h000042;
        i_start = 1'b1;
        // i = edges since the capture edge.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            i_bcd = to_bcd(900000 + i * 7);
            if (o_dv) begin
                dv_n++;
                dv_at  = i;
                dv_bin = o_binary;
            end
            if (i == 25) busy25 = o_busy;
            if (i == 26) busy26 = o_busy;
        end
        i_start = 1'b0;
        $display("held dv_n=%0d dv_at=%0d bin=%06h busy25=%b busy26=%b",
                 dv_n, dv_at, dv_bin, busy25, busy26);
        checks++;
        if (dv_n !== 1 || dv_at !== 24)
            $display("FAIL held_one_conv got n=%0d at=%0d want 1 at 24", dv_n, dv_at);
        else passed++;
        checks++;
        if (dv_bin !== 24'h00002A) $display("FAIL held_value got %06h want 00002a", dv_bin);
        else passed++;
        checks++;
        if (busy25 !== 1'b0 || busy26 !== 1'b1)
            $display("FAIL held_restart got busy25=%b busy26=%b want 0 1", busy25, busy26);
        else passed++;
        // Clean up the conversion that the held start launched.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset_abort();
        int lat, busy_n, dv_n;
        logic [23:0] bin;
        logic err;
        run_conv(24'h000321, lat, busy_n, bin, err);
        @(negedge clk);
        i_bcd   = 24'h999999;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if (o_busy !== 1'b1 || o_binary !== 24'h000141)
            $display("FAIL abort_mid got busy=%b bin=%06h want 1 000141", o_busy, o_binary);
        else passed++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({o_binary, o_dv, o_busy, o_err} !== 27'd0)
            $display("FAIL abort_clear got bin=%06h dv=%b busy=%b err=%b want all 0",
                     o_binary, o_dv, o_busy, o_err);
        else passed++;
        dv_n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (o_dv) dv_n++;
        end
        checks++;
        if (dv_n !== 0) $display("FAIL abort_no_dv got %0d pulses want 0", dv_n);
        else passed++;
        run_conv(24'h000001, lat, busy_n, bin, err);
        checks++;
        if (lat !== 24 || bin !== 24'h000001 || err !== 1'b0)
            $display("FAIL abort_restart got lat=%0d bin=%06h err=%b want 24 000001 0", lat, bin, err);
        else passed++;
    endtask

    task automatic test_sweep();
        int lat, busy_n, value;
        logic [23:0] bin;
        logic err;
        for (int n = 0; n < 300; n++) begin
            case (n)
                0:       value = 999999;
                1:       value = 100000;
                2:       value = 9;
                default: value = int'($urandom_range(0, 999999));
            endcase
            run_conv(to_bcd(value), lat, busy_n, bin, err);
            checks++;
            if (lat !== 24 || bin !== 24'(value) || err !== 1'b0)
                $display("FAIL sweep_%0d got lat=%0d bin=%06h err=%b want 24 %06h 0",
                         value, lat, bin, err, 24'(value));
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_back_to_back();
        test_error();
        test_start_held();
        test_reset_abort();
        test_sweep();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
